// File: rtl/fp_half_div_seq.sv
// fp_half_div_seq: sequential IEEE754 half-precision divider, 12-step restoring mantissa division,
// truncating rounding, subnormals flushed to zero, valid/ready handshake on both sides.
module fp_half_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t             r_state, w_next;
    logic        [15:0] r_a, r_b, r_q;
    logic               r_dbz;
    logic        [11:0] r_rem, r_qq;
    logic        [3:0]  r_cnt;

    logic               w_accept, w_special, w_s, w_dbz, w_ge;
    logic               w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
    logic        [15:0] w_spec_q, w_norm_q;
    logic        [11:0] w_mb, w_sub;
    logic        [9:0]  w_frac;
    logic signed [6:0]  w_e;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_a_zero  = a[14:10] == 5'd0;
    assign w_a_inf   = (&a[14:10]) && (a[9:0] == 10'd0);
    assign w_a_nan   = (&a[14:10]) && (|a[9:0]);
    assign w_b_zero  = b[14:10] == 5'd0;
    assign w_b_inf   = (&b[14:10]) && (b[9:0] == 10'd0);
    assign w_b_nan   = (&b[14:10]) && (|b[9:0]);
    assign w_special = w_a_zero || w_a_inf || w_a_nan || w_b_zero || w_b_inf || w_b_nan;
    assign w_s       = a[15] ^ b[15];
    assign w_spec_q  = (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) ? 16'h7E00 :
                       (w_a_inf || w_b_zero) ? {w_s, 5'h1F, 10'h0} : {w_s, 15'h0};
    assign w_dbz     = w_b_zero && !w_a_zero && !w_a_inf && !w_a_nan;

    // Remainder stays below 2*mb, so 12 bits hold it and bit 11 is clear before each shift.
    assign w_mb  = {2'b01, r_b[9:0]};
    assign w_ge  = r_rem >= w_mb;
    assign w_sub = w_ge ? r_rem - w_mb : r_rem;

    assign w_frac   = r_qq[11] ? r_qq[10:1] : r_qq[9:0];
    assign w_e      = $signed({2'b00, r_a[14:10]}) - $signed({2'b00, r_b[14:10]})
                    + (r_qq[11] ? 7'sd15 : 7'sd14);
    assign w_norm_q = (w_e >= 7'sd31) ? {r_a[15] ^ r_b[15], 5'h1F, 10'h0} :
                      (w_e <= 7'sd0)  ? {r_a[15] ^ r_b[15], 15'h0} :
                                        {r_a[15] ^ r_b[15], w_e[4:0], w_frac};

    assign in_ready    = r_state == IDLE;
    assign out_valid   = r_state == DONE;
    assign q           = r_q;
    assign div_by_zero = r_dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? (w_special ? DONE : DIV) : IDLE;
            DIV:     w_next = (r_cnt == 4'd11) ? NORM : DIV;
            NORM:    w_next = DONE;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= 16'h0;
            r_b   <= 16'h0;
            r_q   <= 16'h0;
            r_dbz <= 1'b0;
            r_rem <= 12'h0;
            r_qq  <= 12'h0;
            r_cnt <= 4'd0;
        end else begin
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_rem <= {2'b01, a[9:0]};
                r_qq  <= 12'h0;
                r_cnt <= 4'd0;
                if (w_special) begin
                    r_q   <= w_spec_q;
                    r_dbz <= w_dbz;
                end
            end
            if (r_state == DIV) begin
                r_rem <= {w_sub[10:0], 1'b0};
                r_qq  <= {r_qq[10:0], w_ge};
                r_cnt <= r_cnt + 4'd1;
            end
            if (r_state == NORM) begin
                r_q   <= w_norm_q;
                r_dbz <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp_half_div_seq.sv
// tb_fp_half_div_seq: directed vectors feed a scoreboard queue; an independent monitor
// checks result, flag, latency, hold stability and drain behaviour whenever out_valid is seen.
module tb_fp_half_div_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] q;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic        dbz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    fp_half_div_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q          (q),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive an operand pair, wait for acceptance, and record the expected result.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] eq,
                        input logic edbz, input int lat, input bit hold);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        sb.push_back('{eq, edbz, cyc, lat});
        if (hold) begin
            a = 16'h7BFF;
            b = 16'h0400;
            repeat (10) @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("result_timeout", sb.size(), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        bit          prev_ov = 1'b0;
        bit          chk_idle = 1'b0;
        logic [15:0] last_q = 16'h0;
        logic        last_dbz = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov  = 1'b0;
                chk_idle = 1'b0;
            end else begin
                if (chk_idle) begin
                    chk("drain_ov", {31'h0, out_valid}, 32'h0);
                    chk("drain_ir", {31'h0, in_ready}, 32'h1);
                    chk_idle = 1'b0;
                end
                if (out_valid) begin
                    chk("done_ir", {31'h0, in_ready}, 32'h0);
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 32'h1, 32'h0);
                    end else begin
                        if (!prev_ov) chk("latency", cyc - sb[0].acc + 1, sb[0].lat);
                        else begin
                            chk("hold_q", {16'h0, q}, {16'h0, last_q});
                            chk("hold_dbz", {31'h0, div_by_zero}, {31'h0, last_dbz});
                        end
                        if (out_ready) begin
                            chk("q", {16'h0, q}, {16'h0, sb[0].q});
                            chk("dbz", {31'h0, div_by_zero}, {31'h0, sb[0].dbz});
                            void'(sb.pop_front());
                            chk_idle = 1'b1;
                        end
                    end
                    last_q   = q;
                    last_dbz = div_by_zero;
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin : stim
        int n;
        #1;
        chk("rst_ov", {31'h0, out_valid}, 32'h0);
        chk("rst_ir", {31'h0, in_ready}, 32'h1);
        chk("rst_q", {16'h0, q}, 32'h0);
        chk("rst_dbz", {31'h0, div_by_zero}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(16'h4200, 16'h4000, 16'h3E00, 1'b0, 14, 1'b0); wait_done();
        send(16'h3C00, 16'h4200, 16'h3555, 1'b0, 14, 1'b0); wait_done();
        send(16'hBC00, 16'h0000, 16'hFC00, 1'b1, 1, 1'b0);  wait_done();
        send(16'h0000, 16'h0000, 16'h7E00, 1'b0, 1, 1'b0);  wait_done();
        send(16'h7BFF, 16'h0400, 16'h7C00, 1'b0, 14, 1'b0); wait_done();
        send(16'h0400, 16'h7BFF, 16'h0000, 1'b0, 14, 1'b0); wait_done();
        send(16'h7E01, 16'h3C00, 16'h7E00, 1'b0, 1, 1'b0);  wait_done();
        send(16'h7C00, 16'h4000, 16'h7C00, 1'b0, 1, 1'b0);  wait_done();
        send(16'h3C00, 16'h7C00, 16'h0000, 1'b0, 1, 1'b0);  wait_done();
        send(16'h7C00, 16'hFC00, 16'h7E00, 1'b0, 1, 1'b0);  wait_done();
        send(16'hFC00, 16'h0000, 16'hFC00, 1'b0, 1, 1'b0);  wait_done();
        send(16'h3C00, 16'h8000, 16'hFC00, 1'b1, 1, 1'b0);  wait_done();
        send(16'h0001, 16'h3C00, 16'h0000, 1'b0, 1, 1'b0);  wait_done();
        send(16'hC400, 16'h4000, 16'hC000, 1'b0, 14, 1'b0); wait_done();

        // Consumer stalls for 5 cycles while the result is held.
        out_ready = 1'b0;
        send(16'h4200, 16'h4000, 16'h3E00, 1'b0, 14, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_ov", {31'h0, out_valid}, 32'h1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done();

        // in_valid stays high with other operands during DIV; result must be unaffected.
        send(16'h3C00, 16'h4200, 16'h3555, 1'b0, 14, 1'b1); wait_done();

        // Reset in the middle of DIV, then a clean transaction with full latency.
        send(16'h4200, 16'h4000, 16'h3E00, 1'b0, 14, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_ov", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_ir", {31'h0, in_ready}, 32'h1);
        chk("mid_rst_q", {16'h0, q}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(16'h4200, 16'h4000, 16'h3E00, 1'b0, 14, 1'b0); wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_half_div_seq.md
FP_HALF_DIV_SEQ -- requirements
Module: fp_half_div_seq

Interface
REQ-001 The block SHALL use these ports, one per line as name, direction, width and meaning:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands.
- a  in  16  IEEE754 half dividend {sign, exp[4:0], frac[9:0]}.
- b  in  16  IEEE754 half divisor, same format.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- q  out  16  IEEE754 half quotient a/b.
- div_by_zero  out  1  flag; b is zero and a is finite and nonzero; valid with out_valid.
REQ-002 The block SHALL have no parameters; widths are fixed to half precision, exponent bias 15.

Function
REQ-003 The FSM SHALL have states IDLE, DIV, NORM and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-004 A transfer SHALL occur on a rising edge with in_valid&&in_ready; the block SHALL register a and b and leave IDLE.
REQ-005 Exponent field 0 SHALL be treated as zero, with subnormals flushed; field 31 with frac 0 SHALL be infinity; field 31 with frac nonzero SHALL be NaN.
REQ-006 Special cases SHALL go IDLE->DONE on the accept edge, giving out_valid 1 cycle after accept, with s = a[15]^b[15]:
- any NaN, 0/0 or inf/inf -> 16'h7E00.
- inf/finite, or nonzero/0 -> {s,5'h1F,10'h0}.
- 0/nonzero, or finite/inf -> {s,15'h0}.
REQ-007 div_by_zero SHALL be set only for the nonzero finite / zero case; otherwise 0.
REQ-008 Normal operands SHALL enter DIV with ma={1,a[9:0]}, mb={1,b[9:0]} (11 bits each) and remainder r=ma.
REQ-009 DIV SHALL perform 12 restoring iterations, one per clock, MSB first:
- quotient bit = (r>=mb).
- if set, r=r-mb.
- then r=r<<1.
- after 12 cycles the 12-bit quotient qq has qq[11] = integer bit; then go to NORM.
REQ-010 NORM SHALL compute, in one cycle, using signed arithmetic of at least 7 bits:
- if qq[11]: frac = qq[10:1], E = ea-eb+15.
- else: frac = qq[9:0], E = ea-eb+14.
- rounding is truncation; the remainder is discarded.
REQ-011 NORM SHALL range-check E:
- E>=31 -> {s,5'h1F,10'h0}.
- E<=0 -> {s,15'h0}.
- else {s,E[4:0],frac}.
- then go to DONE.
REQ-012 Normal latency SHALL be 14 cycles: accept at edge 0, DIV at edges 1-12, NORM at edge 13, with out_valid high after edge 13.
REQ-013 q and div_by_zero SHALL be held stable while out_valid=1 and out_ready=0; DONE->IDLE SHALL occur on an edge with out_ready=1.
REQ-014 There SHALL be no result FIFO; a new operand SHALL NOT be accepted on the edge that drains DONE; in_ready rises the cycle after.
REQ-015 in_valid during DIV, NORM or DONE SHALL be ignored, and the a and b registers SHALL NOT change.

Reset
REQ-016 rst_n=0 SHALL, asynchronously and at any state including mid-DIV, force IDLE, in_ready=1, out_valid=0, q=16'h0, div_by_zero=0, and clear the iteration counter, remainder and quotient.
REQ-017 After rst_n deasserts, the first operand SHALL be accepted on the first edge with in_valid=1; no partial result from before reset SHALL appear.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- a=16'h4200, b=16'h4000 (3/2) -> q=16'h3E00, div_by_zero=0, out_valid 14 cycles after accept.
- a=16'h3C00, b=16'h4200 (1/3) -> q=16'h3555 (qq=12'h555 path, E=13).
- a=16'hBC00, b=16'h0000 -> q=16'hFC00, div_by_zero=1, 1-cycle latency; a=16'h0000, b=16'h0000 -> q=16'h7E00, div_by_zero=0.
- a=16'h7BFF, b=16'h0400 -> q=16'h7C00 (overflow); a=16'h0400, b=16'h7BFF -> q=16'h0000 (underflow).
- Hold out_ready=0 for 5 cycles in DONE -> q, out_valid and in_ready=0 stable; out_ready=1 -> IDLE next edge; in_valid held high during DIV -> no re-capture.
- Assert rst_n=0 at DIV iteration 6 -> out_valid=0 and in_ready=1 immediately; then 16'h4200/16'h4000 -> 16'h3E00 with full 14-cycle latency.
